// File: rtl/btb_assoc_table.sv
// 2-way set-associative branch target buffer with a registered lookup port,
// a resolved-branch update port and a set-by-set flush sequencer.
// Optional feature macro: BTB_COUNTER_EN (adds a 2-bit direction counter per way).
module btb_assoc_table #(
    parameter int SETS   = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              resp_valid,
    output logic              hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush,
    output logic              busy
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 1 - IDX_W;
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] fcnt_q, fcnt_d;

    // Valid and LRU bits are reset; tag/target/counter storage is not.
    logic [SETS-1:0]   vld_q [2];
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag_q [2][SETS];
    logic [ADDR_W-1:0] tgt_q [2][SETS];
`ifdef BTB_COUNTER_EN
    logic [1:0]        ctr_q [2][SETS];
    logic [1:0]        up_ctr;
`endif

    logic              resp_valid_q, hit_q, pred_taken_q;
    logic [ADDR_W-1:0] pred_target_q;

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic [1:0]        lk_match, up_match;
    logic              lk_way, lk_ok, lk_taken;
    logic              up_en, up_hit, up_way, victim, do_alloc, do_hupd;
    logic              unused_pc_lsb;

    // Bit 0 of a PC is always zero for word-aligned instructions.
    assign unused_pc_lsb = lookup_pc[0] ^ upd_pc[0];

    assign lk_idx = lookup_pc[IDX_W:1];
    assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+1];
    assign up_idx = upd_pc[IDX_W:1];
    assign up_tag = upd_pc[ADDR_W-1:IDX_W+1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            assign lk_match[gi] = vld_q[gi][lk_idx] && (tag_q[gi][lk_idx] == lk_tag);
            assign up_match[gi] = vld_q[gi][up_idx] && (tag_q[gi][up_idx] == up_tag);
        end
    endgenerate

    // A double match cannot occur, so way 1 matching alone identifies the way.
    assign lk_way = lk_match[1];
    assign lk_ok  = lookup_valid && (state_q == ST_IDLE) && (|lk_match);
`ifdef BTB_COUNTER_EN
    assign lk_taken = ctr_q[lk_way][lk_idx][1];
    assign up_ctr   = ctr_q[up_way][up_idx];
`else
    assign lk_taken = 1'b1;
`endif

    // Updates are dropped while flushing and on the edge that starts a flush.
    assign up_en    = upd_valid && (state_q == ST_IDLE) && !flush;
    assign up_hit   = |up_match;
    assign up_way   = up_match[1];
    assign victim   = !vld_q[0][up_idx] ? 1'b0 :
                      !vld_q[1][up_idx] ? 1'b1 : lru_q[up_idx];
    assign do_alloc = up_en && !up_hit && upd_taken;
    assign do_hupd  = up_en && up_hit;

    // Valid/LRU maintenance: reset, flush sweep, allocation and hit updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q[0] <= '0;
            vld_q[1] <= '0;
            lru_q    <= '0;
        end else if (state_q == ST_FLUSH) begin
            vld_q[0][fcnt_q] <= 1'b0;
            vld_q[1][fcnt_q] <= 1'b0;
        end else if (do_alloc) begin
            vld_q[victim][up_idx] <= 1'b1;
            lru_q[up_idx]         <= ~victim;
        end else if (do_hupd) begin
`ifdef BTB_COUNTER_EN
            lru_q[up_idx] <= ~up_way;
`else
            if (upd_taken) begin
                lru_q[up_idx] <= ~up_way;
            end else begin
                vld_q[up_way][up_idx] <= 1'b0;
            end
`endif
        end
    end

    // Payload storage writes (tag, target, direction counter).
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_q[victim][up_idx] <= up_tag;
            tgt_q[victim][up_idx] <= upd_target;
        end
        if (do_hupd && upd_taken) begin
            tgt_q[up_way][up_idx] <= upd_target;
        end
`ifdef BTB_COUNTER_EN
        if (do_alloc) begin
            ctr_q[victim][up_idx] <= 2'b10;
        end
        if (do_hupd) begin
            if (upd_taken) begin
                if (up_ctr != 2'b11) ctr_q[up_way][up_idx] <= up_ctr + 2'd1;
            end else begin
                if (up_ctr != 2'b00) ctr_q[up_way][up_idx] <= up_ctr - 2'd1;
            end
        end
`endif
    end

    // Registered lookup response, reading pre-update contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q  <= 1'b0;
            hit_q         <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            resp_valid_q  <= lookup_valid;
            hit_q         <= lk_ok;
            pred_taken_q  <= lk_ok && lk_taken;
            pred_target_q <= lk_ok ? tgt_q[lk_way][lk_idx] : '0;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign hit         = hit_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;

    // Flush sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Flush sequencer next state: sweep sets 0..SETS-1, one per cycle.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                fcnt_d = '0;
                if (flush) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (fcnt_q == LAST_SET) begin
                    state_d = ST_IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    // Flush sequencer outputs.
    always_comb begin
        busy = 1'b0;
        if (state_q == ST_FLUSH) busy = 1'b1;
    end
endmodule

// File: tb/tb_btb_assoc_table.sv
// Scoreboard bench for btb_assoc_table: a recency-ordered entry list models
// the table, expected responses are queued at stimulus time and a monitor
// compares them as the DUT presents them.
module tb_btb_assoc_table;
    localparam int SETS   = 8;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_pc;
    logic              resp_valid, hit, pred_taken, busy;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid, upd_taken, flush;
    logic [ADDR_W-1:0] upd_pc, upd_target;

    always #5 clk = ~clk;

    btb_assoc_table #(.SETS(SETS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .resp_valid(resp_valid), .hit(hit), .pred_taken(pred_taken),
        .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target),
        .flush(flush), .busy(busy)
    );

    // Entry keyed by the full word address; list order is least- to most-recent.
    typedef struct { logic [14:0] key; logic [15:0] tgt; int ctr; } ent_t;
    typedef struct { logic [15:0] pc; logic hit; logic taken; logic [15:0] tgt; } exp_t;

    ent_t cache_m[$];
    exp_t exp_q[$];
    int   flush_left = 0;
    logic exp_busy = 1'b0;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic int find(input logic [14:0] k);
        for (int i = 0; i < cache_m.size(); i++)
            if (cache_m[i].key == k) return i;
        return -1;
    endfunction

    // Reference behaviour for one clock edge, using the inputs sampled there.
    task automatic model_step();
        int   i, cnt, set_i;
        ent_t n;
        exp_t e;
        logic [14:0] k;
        if (reset) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL reset_pending got=%0d pending responses, required 0", exp_q.size());
            end
            exp_q.delete();
            cache_m.delete();
            flush_left = 0;
            exp_busy = 1'b0;
            return;
        end
        if (lookup_valid) begin
            e.pc = lookup_pc; e.hit = 1'b0; e.taken = 1'b0; e.tgt = '0;
            if (flush_left == 0) begin
                i = find(lookup_pc[15:1]);
                if (i >= 0) begin
                    e.hit = 1'b1;
                    e.tgt = cache_m[i].tgt;
`ifdef BTB_COUNTER_EN
                    e.taken = (cache_m[i].ctr >= 2);
`else
                    e.taken = 1'b1;
`endif
                end
            end
            exp_q.push_back(e);
        end
        if (flush_left > 0) begin
            flush_left--;
        end else if (flush) begin
            flush_left = SETS;
            cache_m.delete();
        end else if (upd_valid) begin
            k = upd_pc[15:1];
            i = find(k);
            if (i >= 0) begin
                n = cache_m[i];
                cache_m.delete(i);
                if (upd_taken) begin
                    n.tgt = upd_target;
                    if (n.ctr < 3) n.ctr++;
                    cache_m.push_back(n);
                end else begin
`ifdef BTB_COUNTER_EN
                    if (n.ctr > 0) n.ctr--;
                    cache_m.push_back(n);
`endif
                end
            end else if (upd_taken) begin
                set_i = int'(k) % SETS;
                cnt = 0;
                for (int j = 0; j < cache_m.size(); j++)
                    if (int'(cache_m[j].key) % SETS == set_i) cnt++;
                if (cnt >= 2) begin
                    for (int j = 0; j < cache_m.size(); j++) begin
                        if (int'(cache_m[j].key) % SETS == set_i) begin
                            cache_m.delete(j);
                            break;
                        end
                    end
                end
                n.key = k; n.tgt = upd_target; n.ctr = 2;
                cache_m.push_back(n);
            end
        end
        exp_busy = (flush_left > 0);
    endtask

    task automatic cyc(input logic lv, input logic [15:0] lpc, input logic uv,
                       input logic [15:0] upc, input logic ut, input logic [15:0] utg,
                       input logic fl, input logic rst);
        lookup_valid = lv; lookup_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        flush = fl; reset = rst;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();                      cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0); endtask
    task automatic lk(input logic [15:0] pc);   cyc(1, pc, 0, 16'h0, 0, 16'h0, 0, 0);    endtask
    task automatic up(input logic [15:0] pc, input logic t, input logic [15:0] tg);
        cyc(0, 16'h0, 1, pc, t, tg, 0, 0);
    endtask

    // Monitor: busy every cycle, response fields whenever resp_valid is high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (busy !== exp_busy) begin
                    errors++;
                    $display("FAIL busy got=%b required=%b", busy, exp_busy);
                end
                if (resp_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp got resp_valid=1 required no response");
                    end else begin
                        e = exp_q.pop_front();
                        $display("resp pc=%h hit=%b taken=%b target=%h (exp %b %b %h)",
                                 e.pc, hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
                        if (hit !== e.hit || pred_taken !== e.taken || pred_target !== e.tgt) begin
                            errors++;
                            $display("FAIL resp pc=%h got hit=%b taken=%b target=%h required hit=%b taken=%b target=%h",
                                     e.pc, hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
                        end
                    end
                end else begin
                    checks++;
                    if (resp_valid !== 1'b0 || hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== '0) begin
                        errors++;
                        $display("FAIL idle_outputs got rv=%b hit=%b taken=%b target=%h required 0 0 0 0000",
                                 resp_valid, hit, pred_taken, pred_target);
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] pc_a, pc_b;
        cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 1);
        mon_en = 1'b1;
        cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 1);
        idle();
        // Miss after reset, same-edge update invisible, then hit.
        lk(16'h3000);
        cyc(1, 16'h3000, 1, 16'h3000, 1, 16'h3040, 0, 0);
        lk(16'h3000);
        // Same-set allocations evict the least recently updated entry.
        up(16'h3010, 1, 16'h3110);
        up(16'h3020, 1, 16'h3120);
        lk(16'h3010); lk(16'h3020); lk(16'h3000);
        // Direction counter behaviour and saturation.
        up(16'h3102, 1, 16'h3200);
        up(16'h3102, 0, 16'h0);
        up(16'h3102, 0, 16'h0);
        lk(16'h3102);
        up(16'h3102, 1, 16'h3204);
        up(16'h3102, 1, 16'h3206);
        up(16'h3102, 1, 16'h3208);
        lk(16'h3102);
        up(16'h3102, 1, 16'h320a);
        up(16'h3102, 0, 16'h0);
        lk(16'h3102);
        up(16'h3102, 0, 16'h0);
        lk(16'h3102);
        // Fill four entries, flush, updates dropped during the sweep.
        for (int i = 0; i < 4; i++) up(16'h3400 + 16'(i * 2), 1, 16'h3500 + 16'(i * 4));
        cyc(1, 16'h3400, 0, 16'h0, 0, 16'h0, 1, 0);
        for (int i = 0; i < SETS; i++) cyc(1, 16'h3402, 1, 16'h3600 + 16'(i * 2), 1, 16'h3700, 0, 0);
        for (int i = 0; i < 4; i++) lk(16'h3400 + 16'(i * 2));
        for (int i = 0; i < SETS; i++) lk(16'h3600 + 16'(i * 2));
        // Reset during the third busy cycle.
        up(16'h3300, 1, 16'h3330);
        lk(16'h3300);
        cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 1, 0);
        idle(); idle();
        cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 1);
        lk(16'h3300);
        idle();
        // Randomised traffic over a small PC pool to force conflicts.
        for (int n = 0; n < 600; n++) begin
            pc_a = 16'h3000 + 16'($urandom_range(0, 47) * 2);
            pc_b = 16'h3000 + 16'($urandom_range(0, 47) * 2);
            cyc(1'($urandom_range(0, 3) != 0), pc_a,
                1'($urandom_range(0, 9) < 6), pc_b,
                1'($urandom_range(0, 9) < 7), 16'($urandom_range(0, 32767) * 2),
                1'($urandom_range(0, 59) == 0),
                1'($urandom_range(0, 199) == 0));
        end
        idle(); idle(); idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_resp got=%0d outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
